// File: rtl/pmips_branch_predictor.sv
// Dynamic branch predictor: direct-mapped saturating counters plus a tagged BTB, with debug statistics.
// Optional gshare counter indexing is enabled by defining PMIPS_BP_GSHARE_EN.
module pmips_branch_predictor #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              ready,
  input  logic              pred_valid,
  input  logic [ADDR_W-1:0] pred_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]  CTR_ZERO = '0;
  localparam logic [CTR_W-1:0]  CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0]  CTR_WNT  = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic               ready_q, ready_d;
  logic               run_s;

  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;

  logic [IDX_W-1:0]   p_idx_s, p_cidx_s, u_idx_s, u_cidx_s;
  logic [TAG_W-1:0]   p_tag_s, u_tag_s;
  logic [CTR_W-1:0]   ctr_cur_s, ctr_nxt_s;
  logic [STAT_W-1:0]  lk_q, lk_d, mis_q, mis_d;
  logic               unused_pc_bits_s;

  assign run_s            = (state_q == S_RUN);
  assign ready            = ready_q;
  assign stat_lookups     = lk_q;
  assign stat_mispredicts = mis_q;
  assign unused_pc_bits_s = pred_pc[0] ^ upd_pc[0];

  assign p_idx_s = pred_pc[IDX_W:1];
  assign p_tag_s = pred_pc[ADDR_W-1:IDX_W+1];
  assign u_idx_s = upd_pc[IDX_W:1];
  assign u_tag_s = upd_pc[ADDR_W-1:IDX_W+1];

`ifdef PMIPS_BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  assign p_cidx_s = p_idx_s ^ ghr_q;
  assign u_cidx_s = u_idx_s ^ ghr_q;

  // Global history shifts in each resolved outcome while running.
  always_comb begin
    ghr_d = ghr_q;
    if (run_s && upd_valid) begin
      ghr_d = IDX_W'({ghr_q, upd_taken});
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Global history register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign p_cidx_s = p_idx_s;
  assign u_cidx_s = u_idx_s;
`endif

  // Init sweep walks every entry once, then the FSM parks in RUN until reset.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ready_d = ready_q;
    case (state_q)
      S_INIT: begin
        sweep_d = sweep_q + IDX_ONE;
        if (sweep_q == IDX_LAST) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end else begin
          state_d = S_INIT;
          ready_d = 1'b0;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_INIT;
        sweep_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // FSM state, sweep pointer and ready flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ready_q <= ready_d;
    end
  end

  // Zero-latency lookup of the registered tables; no bypass from a same-cycle update.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    if (run_s && valid_q[p_idx_s] && (tag_q[p_idx_s] == p_tag_s)) begin
      pred_hit    = 1'b1;
      pred_taken  = ctr_q[p_cidx_s][CTR_W-1];
      pred_target = tgt_q[p_idx_s];
    end else begin
      pred_hit    = 1'b0;
      pred_taken  = 1'b0;
      pred_target = '0;
    end
  end

  // Saturating counter step for the resolved branch.
  always_comb begin
    ctr_cur_s = ctr_q[u_cidx_s];
    ctr_nxt_s = ctr_cur_s;
    if (upd_taken) begin
      if (ctr_cur_s == CTR_MAX) begin
        ctr_nxt_s = ctr_cur_s;
      end else begin
        ctr_nxt_s = ctr_cur_s + CTR_ONE;
      end
    end else begin
      if (ctr_cur_s == CTR_ZERO) begin
        ctr_nxt_s = ctr_cur_s;
      end else begin
        ctr_nxt_s = ctr_cur_s - CTR_ONE;
      end
    end
  end

  // Valid bits: cleared by reset and by the sweep, set by taken updates.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (!run_s) begin
      valid_q[sweep_q] <= 1'b0;
    end else if (upd_valid && upd_taken) begin
      valid_q[u_idx_s] <= 1'b1;
    end
  end

  // Counter, tag and target arrays; contents are only meaningful behind a valid bit.
  always_ff @(posedge clock) begin
    if (!run_s) begin
      ctr_q[sweep_q] <= CTR_WNT;
    end else if (upd_valid) begin
      ctr_q[u_cidx_s] <= ctr_nxt_s;
      if (upd_taken) begin
        tag_q[u_idx_s] <= u_tag_s;
        tgt_q[u_idx_s] <= upd_target;
      end
    end
  end

  // Statistics: clear wins over increment, both saturate, nothing counts during init.
  always_comb begin
    lk_d  = lk_q;
    mis_d = mis_q;
    if (run_s) begin
      if (stat_clr) begin
        lk_d  = '0;
        mis_d = '0;
      end else begin
        if (pred_valid && (lk_q != STAT_MAX)) begin
          lk_d = lk_q + STAT_ONE;
        end else begin
          lk_d = lk_q;
        end
        if (upd_valid && upd_mispredict && (mis_q != STAT_MAX)) begin
          mis_d = mis_q + STAT_ONE;
        end else begin
          mis_d = mis_q;
        end
      end
    end else begin
      lk_d  = lk_q;
      mis_d = mis_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lk_q  <= '0;
      mis_q <= '0;
    end else begin
      lk_q  <= lk_d;
      mis_q <= mis_d;
    end
  end

endmodule

// File: tb/tb_pmips_branch_predictor.sv
// Directed bench for pmips_branch_predictor: lookup expectations go through a scoreboard queue.
module tb_pmips_branch_predictor;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ready;
  logic        pred_valid = 1'b0;
  logic [15:0] pred_pc = 16'h0000;
  logic        pred_hit, pred_taken;
  logic [15:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = 16'h0000;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_target = 16'h0000;
  logic        upd_mispredict = 1'b0;
  logic        stat_clr = 1'b0;
  logic [15:0] stat_lookups, stat_mispredicts;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [15:0] tgt;
  } exp_t;
  exp_t sb[$];

  pmips_branch_predictor #(.ADDR_W(16), .ENTRIES(16), .CTR_W(2), .STAT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .ready(ready),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_hit(pred_hit),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_clr(stat_clr), .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk({e.name, "_hit"}, 32'(pred_hit), 32'(e.hit));
      chk({e.name, "_taken"}, 32'(pred_taken), 32'(e.taken));
      chk({e.name, "_target"}, 32'(pred_target), 32'(e.tgt));
    end
  endtask

  task automatic look(input string name, input logic [15:0] pc, input logic h, input logic t,
                      input logic [15:0] tgt);
    pred_pc = pc;
    sb.push_back('{name, h, t, tgt});
    #1;
    pop_check();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic upd(input logic [15:0] pc, input logic t, input logic [15:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tgt;
    tick();
    upd_valid = 1'b0; upd_taken = 1'b0;
  endtask

  initial begin
    // Reset and init sweep; activity during the sweep must be ignored.
    #2;
    chk("rst_ready", 32'(ready), 32'(0));
    chk("rst_lookups", 32'(stat_lookups), 32'(0));
    chk("rst_mispredicts", 32'(stat_mispredicts), 32'(0));
    tick();
    reset_n = 1'b1;
    pred_valid = 1'b1;
    upd_valid = 1'b1; upd_pc = 16'h0040; upd_taken = 1'b1; upd_target = 16'h0abc;
    upd_mispredict = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("init_ready_%0d", i), 32'(ready), 32'(i == 16));
    end
    pred_valid = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    chk("init_lookups", 32'(stat_lookups), 32'(0));
    chk("init_mispredicts", 32'(stat_mispredicts), 32'(0));
    look("t1_miss", 16'h0040, 1'b0, 1'b0, 16'h0000);

    // Counter walk on idx 0: 01 -> 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00 -> 01 -> 10.
    upd(16'h0040, 1'b1, 16'h0010);
    look("t2_first_taken", 16'h0040, 1'b1, 1'b1, 16'h0010);
    upd(16'h0040, 1'b1, 16'h0010);
    upd(16'h0040, 1'b1, 16'h0010);
    look("t3_sat_hi", 16'h0040, 1'b1, 1'b1, 16'h0010);
    upd(16'h0040, 1'b0, 16'h7777);
    look("t3_down_10", 16'h0040, 1'b1, 1'b1, 16'h0010);
    upd(16'h0040, 1'b0, 16'h7777);
    look("t3_down_01", 16'h0040, 1'b1, 1'b0, 16'h0010);
    upd(16'h0040, 1'b0, 16'h7777);
    upd(16'h0040, 1'b0, 16'h7777);
    look("t3_sat_lo", 16'h0040, 1'b1, 1'b0, 16'h0010);
    upd(16'h0040, 1'b1, 16'h0010);
    look("t3_up_01", 16'h0040, 1'b1, 1'b0, 16'h0010);
    upd(16'h0040, 1'b1, 16'h0010);
    look("t3_up_10", 16'h0040, 1'b1, 1'b1, 16'h0010);

    // Same-cycle lookup and update: the lookup sees pre-update contents.
    pred_valid = 1'b1; pred_pc = 16'h0040;
    upd_valid = 1'b1; upd_pc = 16'h0040; upd_taken = 1'b0; upd_target = 16'h0000;
    sb.push_back('{"t5_same_cycle", 1'b1, 1'b1, 16'h0010});
    #1;
    pop_check();
    tick();
    pred_valid = 1'b0; upd_valid = 1'b0;
    look("t5_next_cycle", 16'h0040, 1'b1, 1'b0, 16'h0010);

    // Aliasing on idx 0 with a different tag.
    look("t4_alias_miss", 16'h0440, 1'b0, 1'b0, 16'h0000);
    upd(16'h0440, 1'b1, 16'h0200);
    look("t4_evicted", 16'h0040, 1'b0, 1'b0, 16'h0000);
    look("t4_new_owner", 16'h0440, 1'b1, 1'b1, 16'h0200);
    upd(16'h0040, 1'b0, 16'h5555);
    look("t4_nt_mismatch", 16'h0440, 1'b1, 1'b0, 16'h0200);
    upd(16'h0446, 1'b1, 16'h1234);
    look("idx3_hit", 16'h0446, 1'b1, 1'b1, 16'h1234);
    look("idx2_miss", 16'h0444, 1'b0, 1'b0, 16'h0000);

    // Lookup statistics: one count from the same-cycle step so far.
    chk("lk_after_run", 32'(stat_lookups), 32'(1));
    chk("mis_after_run", 32'(stat_mispredicts), 32'(0));
    pred_valid = 1'b1;
    repeat (5) tick();
    chk("lk_plus5", 32'(stat_lookups), 32'(6));
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("lk_clr_priority", 32'(stat_lookups), 32'(0));
    tick();
    pred_valid = 1'b0;
    chk("lk_after_clr", 32'(stat_lookups), 32'(1));

    // Mispredict statistics and saturation.
    upd_valid = 1'b1; upd_pc = 16'h0080; upd_taken = 1'b1; upd_target = 16'h0100;
    upd_mispredict = 1'b1;
    repeat (3) tick();
    chk("mis_3", 32'(stat_mispredicts), 32'(3));
    repeat (65535) @(posedge clock);
    #1;
    chk("mis_sat", 32'(stat_mispredicts), 32'(16'hffff));
    repeat (2) tick();
    chk("mis_hold", 32'(stat_mispredicts), 32'(16'hffff));
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("mis_clr", 32'(stat_mispredicts), 32'(0));

    // Mid-run reset wipes the tables and re-runs the sweep.
    reset_n = 1'b0;
    pred_pc = 16'h0446;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'(0));
    chk("mid_rst_hit", 32'(pred_hit), 32'(0));
    chk("mid_rst_lookups", 32'(stat_lookups), 32'(0));
    tick();
    reset_n = 1'b1;
    repeat (15) tick();
    chk("resweep_ready_15", 32'(ready), 32'(0));
    tick();
    chk("resweep_ready_16", 32'(ready), 32'(1));
    look("post_rst_0440", 16'h0440, 1'b0, 1'b0, 16'h0000);
    look("post_rst_0446", 16'h0446, 1'b0, 1'b0, 16'h0000);
    look("post_rst_0080", 16'h0080, 1'b0, 1'b0, 16'h0000);

`ifdef PMIPS_BP_GSHARE_EN
    upd(16'h0040, 1'b1, 16'h0010);
    upd(16'h0040, 1'b1, 16'h0010);
    chk("ghr_tt", 32'(dut.ghr_q), 32'(4'b0011));
`endif

    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
